fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, which is the PC loaded on reset.
REQ-002 The block SHALL have port clk, input, width 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, width 1, a synchronous active-high reset.
REQ-004 The block SHALL have port StallF, input, width 1; 1 = PC advances, 0 = PC holds (enable polarity, as driven by the load-use hazard unit).
REQ-005 The block SHALL have port StallD, input, width 1; 1 = IF/ID register loads, 0 = IF/ID holds (enable polarity).
REQ-006 The block SHALL have port redirect_D, input, width 1, indicating that a taken branch, jump or jr was resolved in ID this cycle.
REQ-007 The block SHALL have port redirect_target_D, input, width 32, the redirect destination, valid only while redirect_D=1.
REQ-008 The block SHALL have port imem_data, input, width 32, the instruction word read combinationally at imem_addr.
REQ-009 The block SHALL have port imem_addr, output, width 32, which equals the current PC_F register.
REQ-010 The block SHALL have port InstrD, output, width 32, the instruction held in the IF/ID register.
REQ-011 The block SHALL have port PCPlus4D, output, width 32, the PC+4 of InstrD.
REQ-012 The block SHALL have port ValidD, output, width 1, which is 1 when InstrD is a real fetched instruction and 0 when it is a bubble.
REQ-013 The block SHALL have port stall_count, output, width 16, a saturating count of cycles with StallF=0.

Function
REQ-014 imem_addr SHALL equal PC_F combinationally, with no added latency.
REQ-015 The sequential PC SHALL be PC_F+4, computed modulo 2^32, so that 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-016 The PC selection priority, when StallF=1, SHALL be as follows:
- redirect_D=1 selects redirect_target_D;
- otherwise, pending_valid=1 selects pending_target;
- otherwise, the sequential PC is selected.
REQ-017 When StallF=1, PC_F SHALL load the selected PC on the next edge.
REQ-018 When StallF=0, PC_F SHALL hold its value.
REQ-019 If redirect_D=1 while StallF=0, the block SHALL set pending_valid=1 and capture pending_target=redirect_target_D.
REQ-020 A later redirect_D arriving while pending_valid=1 and StallF=0 SHALL overwrite pending_target.
REQ-021 pending_valid SHALL clear on the first edge with StallF=1; the applied target follows REQ-016 priority.
REQ-022 When StallD=0, the IF/ID register (InstrD, PCPlus4D, ValidD) SHALL hold, regardless of redirect_D or pending_valid.
REQ-023 When StallD=1 and (redirect_D=1 or pending_valid=1), the IF/ID register SHALL load a bubble: InstrD=32'h0000_0000, PCPlus4D=32'h0000_0000, ValidD=0.
REQ-024 When StallD=1 and neither redirect_D nor pending_valid is set, the IF/ID register SHALL load InstrD=imem_data, PCPlus4D=PC_F+4 and ValidD=1.
REQ-025 The fetch latency SHALL be one cycle: the instruction at PC_F appears on InstrD after the next edge, given StallD=1.
REQ-026 stall_count SHALL increment by 1 on each edge with StallF=0, saturate at 16'hFFFF, and never wrap.
REQ-027 The simultaneous case StallF=0, StallD=1, redirect_D=1 SHALL be handled as follows:
- PC_F holds;
- the target is captured as pending;
- IF/ID loads a bubble.

Reset
REQ-028 reset=1 at an edge SHALL set PC_F=RESET_PC, InstrD=0, PCPlus4D=0, ValidD=0, pending_valid=0, pending_target=0 and stall_count=0.
REQ-029 reset SHALL override StallF, StallD and redirect_D, including when asserted mid-stall or with a pending redirect, and no pending redirect SHALL survive reset.
REQ-030 On the first edge after reset deasserts with StallF=StallD=1, the block SHALL fetch from RESET_PC, so that ValidD=1 with PCPlus4D=RESET_PC+4.

Verification
REQ-031 Sequential fetch: release reset, hold StallF=StallD=1, imem returns {addr}. Required response: imem_addr steps 0,4,8,...; InstrD lags by one cycle; PCPlus4D=addr+4; ValidD=1.
REQ-032 Load-use stall: at PC_F=0x10, drive StallF=StallD=0 for 1 cycle. Required response: PC_F stays 0x10; InstrD and ValidD hold; stall_count goes 0 to 1; fetch then resumes at 0x14.
REQ-033 Taken branch: drive redirect_D=1 with target 0x40 and StallF=StallD=1. Required response: next edge imem_addr=0x40 and ValidD=0 with InstrD=0; the following edge has InstrD=mem[0x40].
REQ-034 Redirect during stall: drive redirect_D=1 with target 0x80 while StallF=0, then StallF=1 with redirect_D=0. Required response: PC_F holds, then loads 0x80; IF/ID loads a bubble on both cycles when StallD=1.
REQ-035 Wrap and saturation:
- PC_F=0xFFFF_FFFC advances to 0x0000_0000;
- StallF=0 held for 70000 cycles leaves stall_count=16'hFFFF.
REQ-036 Reset mid-operation: assert reset with pending_valid=1 and stall_count=5. Required response: next edge PC_F=RESET_PC, stall_count=0, ValidD=0, and there is no later jump to the old target.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register with deferred redirects, IF/ID pipeline register
// with bubble insertion, and a saturating count of stalled fetch cycles.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        redirect_D,
    input  logic [31:0] redirect_target_D,
    input  logic [31:0] imem_data,
    output logic [31:0] imem_addr,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [15:0] stall_count
);

    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;
    logic [31:0] pc_next;
    logic [31:0] pending_target;
    logic        pending_valid;
    logic        squash;

    always_comb begin
        pc_plus4_f = pc_f + 32'd4;
        squash     = redirect_D | pending_valid;
        pc_next    = pc_plus4_f;
        if (redirect_D) begin
            pc_next = redirect_target_D;
        end else if (pending_valid) begin
            pc_next = pending_target;
        end
    end

    assign imem_addr = pc_f;

    // A redirect seen while the PC is frozen is parked until the PC may advance again.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f           <= RESET_PC;
            pending_valid  <= 1'b0;
            pending_target <= '0;
        end else if (StallF) begin
            pc_f          <= pc_next;
            pending_valid <= 1'b0;
        end else if (redirect_D) begin
            pending_valid  <= 1'b1;
            pending_target <= redirect_target_D;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            InstrD   <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (StallD) begin
            if (squash) begin
                InstrD   <= '0;
                PCPlus4D <= '0;
                ValidD   <= 1'b0;
            end else begin
                InstrD   <= imem_data;
                PCPlus4D <= pc_plus4_f;
                ValidD   <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (!StallF && (stall_count != '1)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF;
    logic        StallD;
    logic        redirect_D;
    logic [31:0] redirect_target_D;
    logic [31:0] imem_data;
    logic [31:0] imem_addr;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic [15:0] stall_count;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_ptgt;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    int          m_cnt;

    fetch_stage #(.RESET_PC(TB_RESET_PC)) dut (
        .clk               (clk),
        .reset             (reset),
        .StallF            (StallF),
        .StallD            (StallD),
        .redirect_D        (redirect_D),
        .redirect_target_D (redirect_target_D),
        .imem_data         (imem_data),
        .imem_addr         (imem_addr),
        .InstrD            (InstrD),
        .PCPlus4D          (PCPlus4D),
        .ValidD            (ValidD),
        .stall_count       (stall_count)
    );

    always #5 clk = ~clk;

    // Instruction memory returns its own address as the instruction word.
    assign imem_data = imem_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a;
    endfunction

    task automatic model_edge();
        logic [31:0] pc_old;
        logic        pend_old;
        pc_old   = m_pc;
        pend_old = m_pend;
        if (reset) begin
            m_pc = TB_RESET_PC; m_pend = 1'b0; m_ptgt = '0;
            m_instr = '0; m_pc4 = '0; m_valid = 1'b0; m_cnt = 0;
        end else begin
            if (StallD) begin
                if (redirect_D || pend_old) begin
                    m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
                end else begin
                    m_instr = mem_word(pc_old); m_pc4 = pc_old + 32'd4; m_valid = 1'b1;
                end
            end
            if (StallF) begin
                if (redirect_D)    m_pc = redirect_target_D;
                else if (pend_old) m_pc = m_ptgt;
                else               m_pc = pc_old + 32'd4;
                m_pend = 1'b0;
            end else begin
                if (redirect_D) begin
                    m_pend = 1'b1; m_ptgt = redirect_target_D;
                end
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sf, input logic sd, input logic rd, input logic [31:0] tgt);
        StallF = sf; StallD = sd; redirect_D = rd; redirect_target_D = tgt;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 1'b1, 32'hDEAD_BEE0);
        do_reset();
        checks++;
        if (imem_addr !== TB_RESET_PC) begin
            failures++; $display("FAIL reset_pc actual=%h required=%h", imem_addr, TB_RESET_PC);
        end
        checks++;
        if (InstrD !== 32'h0 || PCPlus4D !== 32'h0 || ValidD !== 1'b0) begin
            failures++; $display("FAIL reset_ifid actual=%h/%h/%b required=0/0/0", InstrD, PCPlus4D, ValidD);
        end
        checks++;
        if (stall_count !== 16'h0) begin
            failures++; $display("FAIL reset_count actual=%h required=0", stall_count);
        end
        step();
        checks++;
        if (ValidD !== 1'b1 || PCPlus4D !== TB_RESET_PC + 32'd4 || InstrD !== TB_RESET_PC) begin
            failures++; $display("FAIL first_fetch actual=%b/%h/%h required=1/%h/%h",
                                 ValidD, PCPlus4D, InstrD, TB_RESET_PC + 32'd4, TB_RESET_PC);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int unsigned i = 1; i <= 8; i++) begin
            step();
            checks++;
            if (imem_addr !== 32'(4 * i) || InstrD !== 32'(4 * (i - 1)) ||
                PCPlus4D !== 32'(4 * i) || ValidD !== 1'b1) begin
                failures++;
                $display("FAIL seq_%0d actual addr=%h instr=%h pc4=%h v=%b required addr=%h instr=%h pc4=%h v=1",
                         i, imem_addr, InstrD, PCPlus4D, ValidD, 32'(4 * i), 32'(4 * (i - 1)), 32'(4 * i));
            end
        end
    endtask

    task automatic test_load_use();
        do_reset();
        repeat (4) step();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        checks++;
        if (imem_addr !== 32'h10 || InstrD !== 32'hC || ValidD !== 1'b1 || stall_count !== 16'd1) begin
            failures++;
            $display("FAIL load_use_hold actual addr=%h instr=%h v=%b cnt=%0d required addr=10 instr=c v=1 cnt=1",
                     imem_addr, InstrD, ValidD, stall_count);
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        checks++;
        if (imem_addr !== 32'h14 || InstrD !== 32'h10 || PCPlus4D !== 32'h14) begin
            failures++;
            $display("FAIL load_use_resume actual addr=%h instr=%h pc4=%h required 14/10/14", imem_addr, InstrD, PCPlus4D);
        end
    endtask

    task automatic test_branch();
        do_reset();
        repeat (2) step();
        drive(1'b1, 1'b1, 1'b1, 32'h40);
        step();
        checks++;
        if (imem_addr !== 32'h40 || ValidD !== 1'b0 || InstrD !== 32'h0) begin
            failures++;
            $display("FAIL branch_bubble actual addr=%h v=%b instr=%h required 40/0/0", imem_addr, ValidD, InstrD);
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        checks++;
        if (InstrD !== mem_word(32'h40) || ValidD !== 1'b1 || imem_addr !== 32'h44) begin
            failures++;
            $display("FAIL branch_target actual instr=%h v=%b addr=%h required 40/1/44", InstrD, ValidD, imem_addr);
        end
    endtask

    task automatic test_redirect_stall();
        do_reset();
        repeat (3) step();
        drive(1'b0, 1'b1, 1'b1, 32'h80);
        step();
        checks++;
        if (imem_addr !== 32'hC || ValidD !== 1'b0 || InstrD !== 32'h0 || PCPlus4D !== 32'h0) begin
            failures++;
            $display("FAIL rstall_hold actual addr=%h v=%b instr=%h required c/0/0", imem_addr, ValidD, InstrD);
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        checks++;
        if (imem_addr !== 32'h80 || ValidD !== 1'b0 || InstrD !== 32'h0) begin
            failures++;
            $display("FAIL rstall_apply actual addr=%h v=%b instr=%h required 80/0/0", imem_addr, ValidD, InstrD);
        end
        step();
        checks++;
        if (InstrD !== 32'h80 || ValidD !== 1'b1 || imem_addr !== 32'h84) begin
            failures++;
            $display("FAIL rstall_fetch actual instr=%h v=%b addr=%h required 80/1/84", InstrD, ValidD, imem_addr);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        checks++;
        if (imem_addr !== 32'h0 || InstrD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0 || ValidD !== 1'b1) begin
            failures++;
            $display("FAIL wrap actual addr=%h instr=%h pc4=%h v=%b required 0/fffffffc/0/1",
                     imem_addr, InstrD, PCPlus4D, ValidD);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        for (int unsigned i = 0; i < 70000; i++) begin
            StallD = 1'($urandom_range(0, 1));
            step();
        end
        checks++;
        if (stall_count !== 16'hFFFF || imem_addr !== TB_RESET_PC) begin
            failures++;
            $display("FAIL saturate actual cnt=%h addr=%h required ffff/%h", stall_count, imem_addr, TB_RESET_PC);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (4) step();
        drive(1'b0, 1'b1, 1'b1, 32'h200);
        step();
        checks++;
        if (stall_count !== 16'd5) begin
            failures++; $display("FAIL mid_count actual=%0d required=5", stall_count);
        end
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 32'h300);
        step();
        reset = 1'b0;
        checks++;
        if (imem_addr !== TB_RESET_PC || stall_count !== 16'd0 || ValidD !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset actual addr=%h cnt=%0d v=%b required %h/0/0", imem_addr, stall_count, ValidD, TB_RESET_PC);
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        for (int unsigned i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (imem_addr !== TB_RESET_PC + 32'(4 * i) || ValidD !== 1'b1) begin
                failures++;
                $display("FAIL mid_no_jump_%0d actual addr=%h v=%b required %h/1", i, imem_addr, ValidD,
                         TB_RESET_PC + 32'(4 * i));
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int unsigned i = 0; i < 400; i++) begin
            reset             = ($urandom_range(0, 59) == 0);
            StallF            = ($urandom_range(0, 9) > 2);
            StallD            = ($urandom_range(0, 9) > 1);
            redirect_D        = ($urandom_range(0, 3) == 0);
            redirect_target_D = {$urandom_range(0, 255), 2'b00};
            step();
            checks++;
            if (imem_addr !== m_pc || InstrD !== m_instr || PCPlus4D !== m_pc4 ||
                ValidD !== m_valid || stall_count !== m_cnt[15:0]) begin
                failures++;
                $display("FAIL rand_%0d actual addr=%h instr=%h pc4=%h v=%b cnt=%0d required addr=%h instr=%h pc4=%h v=%b cnt=%0d",
                         i, imem_addr, InstrD, PCPlus4D, ValidD, stall_count,
                         m_pc, m_instr, m_pc4, m_valid, m_cnt);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        m_pc = '0; m_pend = 1'b0; m_ptgt = '0;
        m_instr = '0; m_pc4 = '0; m_valid = 1'b0; m_cnt = 0;
        #1;
        test_reset();
        test_sequential();
        test_load_use();
        test_branch();
        test_redirect_stall();
        test_wrap();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
